// File: rtl/gsm_pkg.sv
// gsm_pkg: shared FSM states and step deltas for gray_step_monitor
package gsm_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, TRACK = 2'd1, FAULT = 2'd2} gsm_state_t;
  localparam logic [3:0] DELTA_UP = 4'd1;
  localparam logic [3:0] DELTA_DN = 4'd15;
endpackage

// File: rtl/gray2bin4.sv
// gray2bin4: combinational 4-bit Gray to binary conversion
module gray2bin4 (
  input  logic [3:0] g,
  output logic [3:0] b
);
  assign b = {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
endmodule

// File: rtl/gray_step_monitor.sv
// gray_step_monitor: tracks a 4-bit Gray up/down counter, pulses on single steps, flags illegal jumps; WRAP_CNT output enabled by GRAY_STEP_MONITOR_WRAP_CNT_EN
module gray_step_monitor
  import gsm_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [3:0]              GIN,
  input  logic                    CLR_ERR,
  output logic [3:0]              BIN,
  output logic                    STEP,
  output logic                    DIR,
  output logic                    ERR,
  output logic signed [POS_W-1:0] POS
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
  ,
  output logic [7:0]              WRAP_CNT
`endif
);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  gsm_state_t state;
  logic [3:0] b_new, delta;
  logic up, dn, bad;
  logic signed [POS_W-1:0] pos_inc, pos_dec;
  gray2bin4 u_g2b (.g(GIN), .b(b_new));
  // classify the sampled transition; clear request suppresses any step or fault
  always_comb begin
    delta   = b_new - BIN;
    up      = !CLR_ERR && EN && state == TRACK && delta == DELTA_UP;
    dn      = !CLR_ERR && EN && state == TRACK && delta == DELTA_DN;
    bad     = !CLR_ERR && EN && state == TRACK && !up && !dn && delta != 4'd0;
    pos_inc = POS == POS_MAX ? POS : POS + POS_W'(1);
    pos_dec = POS == POS_MIN ? POS : POS - POS_W'(1);
  end
  // tracker state and registered outputs; BIN always follows the last sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      BIN   <= 4'd0;
      STEP  <= 1'b0;
      DIR   <= 1'b1;
      ERR   <= 1'b0;
      POS   <= '0;
    end else begin
      BIN   <= EN ? b_new : BIN;
      STEP  <= up || dn;
      DIR   <= up ? 1'b1 : dn ? 1'b0 : DIR;
      ERR   <= !CLR_ERR && (ERR || bad);
      POS   <= up ? pos_inc : dn ? pos_dec : POS;
      state <= CLR_ERR ? INIT : bad ? FAULT : (state == INIT && EN) ? TRACK : state;
    end
  end
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
  // count net wraps across the 15/0 boundary, modulo 256
  always_ff @(posedge CLK) begin
    if (RST) WRAP_CNT <= 8'd0;
    else WRAP_CNT <= (up && BIN == 4'd15) ? WRAP_CNT + 8'd1 : (dn && BIN == 4'd0) ? WRAP_CNT - 8'd1 : WRAP_CNT;
  end
`endif
endmodule

// File: tb/tb_gray_step_monitor.sv
// tb_gray_step_monitor: scoreboard bench for gray_step_monitor at POS_W 8 and 4
module tb_gray_step_monitor;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [3:0] gin = 4'd0;
  logic [3:0] bin8, bin4;
  logic step8, step4, dir8, dir4, err8, err4;
  logic signed [7:0] pos8;
  logic signed [3:0] pos4;
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
  logic [7:0] wrap8, wrap4;
`endif
  typedef struct {int bin; int step; int dir; int err; int p8; int p4; int wrap;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_st, m_bin, m_dir, m_err, m_p8, m_p4, m_wrap, m_step;

  gray_step_monitor #(.POS_W(8)) dut8 (
    .CLK(clk), .RST(rst), .EN(en), .GIN(gin), .CLR_ERR(clr),
    .BIN(bin8), .STEP(step8), .DIR(dir8), .ERR(err8), .POS(pos8)
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
    , .WRAP_CNT(wrap8)
`endif
  );
  gray_step_monitor #(.POS_W(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .GIN(gin), .CLR_ERR(clr),
    .BIN(bin4), .STEP(step4), .DIR(dir4), .ERR(err4), .POS(pos4)
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
    , .WRAP_CNT(wrap4)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx, mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    return v > mx ? mx : v < mn ? mn : v;
  endfunction

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic model(input logic r, input logic e, input logic c, input logic [3:0] g);
    int nb, d;
    m_step = 0;
    if (r) begin
      m_st = 0; m_bin = 0; m_dir = 1; m_err = 0; m_p8 = 0; m_p4 = 0; m_wrap = 0;
    end else if (c) begin
      m_err = 0;
      m_st = 0;
      if (e) m_bin = g2b(g);
    end else if (e) begin
      nb = g2b(g);
      d = (nb - m_bin) & 15;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        if (d == 1) begin
          m_step = 1; m_dir = 1; m_p8 = sat(m_p8 + 1, 8); m_p4 = sat(m_p4 + 1, 4);
          if (m_bin == 15) m_wrap = (m_wrap + 1) & 255;
        end else if (d == 15) begin
          m_step = 1; m_dir = 0; m_p8 = sat(m_p8 - 1, 8); m_p4 = sat(m_p4 - 1, 4);
          if (m_bin == 0) m_wrap = (m_wrap + 255) & 255;
        end else if (d != 0) begin
          m_err = 1; m_st = 2;
        end
      end
      m_bin = nb;
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic c, input logic [3:0] b);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; clr = c; gin = b ^ (b >> 1);
    model(r, e, c, gin);
    x = '{m_bin, m_step, m_dir, m_err, m_p8, m_p4, m_wrap};
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("scoreboard_empty", 0, 1);
    else begin
      x = q.pop_front();
      chk("bin8", bin8, x.bin);
      chk("bin4", bin4, x.bin);
      chk("step8", step8, x.step);
      chk("step4", step4, x.step);
      chk("dir8", dir8, x.dir);
      chk("dir4", dir4, x.dir);
      chk("err8", err8, x.err);
      chk("err4", err4, x.err);
      chk("pos8", pos8, x.p8);
      chk("pos4", pos4, x.p4);
`ifdef GRAY_STEP_MONITOR_WRAP_CNT_EN
      chk("wrap8", wrap8, x.wrap);
      chk("wrap4", wrap4, x.wrap);
`endif
    end
  endtask

  task automatic sample(input logic [3:0] b);
    cyc(1'b0, 1'b1, 1'b0, b);
  endtask

  initial begin
    logic [3:0] nb;
    m_st = 0; m_bin = 0; m_dir = 1; m_err = 0; m_p8 = 0; m_p4 = 0; m_wrap = 0; m_step = 0;
    cyc(1'b1, 1'b1, 1'b1, 4'd9);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    sample(4'd0);
    sample(4'd1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    sample(4'd0);
    sample(4'd15);
    sample(4'd14);
    cyc(1'b0, 1'b0, 1'b0, 4'd13);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    sample(4'd0);
    sample(4'd1);
    sample(4'd2);
    sample(4'd6);
    sample(4'd7);
    sample(4'd8);
    cyc(1'b0, 1'b0, 1'b1, 4'd8);
    sample(4'd8);
    sample(4'd9);
    sample(4'd12);
    cyc(1'b0, 1'b1, 1'b1, 4'd3);
    sample(4'd4);
    sample(4'd5);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i <= 5; i++) sample(4'(i));
    sample(4'd11);
    sample(4'd12);
    cyc(1'b1, 1'b1, 1'b1, 4'd3);
    sample(4'd0);
    for (int i = 1; i <= 20; i++) sample(4'(i));
    cyc(1'b0, 1'b0, 1'b0, 4'd9);
    for (int i = 19; i >= -25; i--) sample(4'(i));
    for (int i = 0; i < 400; i++) begin
      nb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_bin + $urandom_range(0, 2) - 1);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, nb);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
